// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 device-to-host receiver.
//   - Frame geometry: 11 bits per frame (start, 8 data LSB first, odd parity, stop).
//   - Bit-index constants used by the deframer to route each received bit.
//   - odd_parity_ok(): true when the data byte plus parity bit has odd weight.
package ps2_pkg;

    localparam int   PS2_FRAME_BITS   = 11;
    localparam logic PS2_START        = 1'b0;
    localparam logic PS2_STOP         = 1'b1;

    localparam int   PS2_BIT_DATA_LSB = 1;
    localparam int   PS2_BIT_PARITY   = 9;
    localparam int   PS2_BIT_STOP     = PS2_FRAME_BITS - 1;

    // Position within the frame; 0 doubles as "no frame in progress".
    typedef logic [3:0] bitcnt_t;

    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous FIFO holding received scan-code bytes.
// Ports:
//   clk, clr      - clock and synchronous active-high reset (empties the FIFO)
//   push, wdata   - write request and byte; ignored when full unless a pop
//                   happens on the same edge
//   pop           - read request; ignored when empty
//   rdata         - byte at the head, combinational from registered state
//   empty, full   - occupancy flags
module ps2_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [DEPTH_LOG2:0] wptr_q, rptr_q;
    logic                do_push, do_pop;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                   (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);

    assign do_pop  = pop & ~empty;
    // A simultaneous pop frees the head slot, so a push into a full FIFO succeeds.
    assign do_push = push & (~full | do_pop);

    assign rdata = mem_q[rptr_q[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (clr) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage carries no reset; contents are only visible through valid pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= wdata;
    end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver.
// Synchronises the raw PS/2 lines, deframes 11-bit frames, checks start,
// odd parity and stop, and queues good bytes for the scan-code handler.
// Ports:
//   clk, clr      - system clock and synchronous active-high reset
//   ps2_clk       - raw PS/2 clock line (asynchronous, idle high)
//   ps2_data      - raw PS/2 data line (asynchronous, idle high)
//   nextdata_n    - active-low pop request, one cycle low per byte
//   data          - byte at the FIFO head, valid while ready=1
//   ready         - FIFO non-empty
//   overflow      - sticky: a good byte was dropped because the FIFO was full
//   frame_err     - one-cycle pulse: a malformed frame was discarded
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    // [0]=s1, [1]=s2, [2]=s3 history; all idle-high after reset.
    logic [2:0]      clk_sync_q;
    logic [1:0]      data_sync_q;

    bitcnt_t         bitcnt_q,    bitcnt_d;
    logic [7:0]      shift_q,     shift_d;
    logic            start_q,     start_d;
    logic            parity_q,    parity_d;
    logic [TO_W-1:0] to_q,        to_d;
    logic            overflow_q,  overflow_d;
    logic            frame_err_q, frame_err_d;

    logic            fall, rx_bit, frame_good;
    logic            fifo_empty, fifo_full, pop_eff;

    assign fall    = clk_sync_q[2] & ~clk_sync_q[1];
    assign rx_bit  = data_sync_q[1];
    assign pop_eff = ~nextdata_n & ~fifo_empty;

    always_comb begin
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        start_d     = start_q;
        parity_d    = parity_q;
        to_d        = to_q;
        overflow_d  = overflow_q;
        frame_err_d = 1'b0;
        frame_good  = 1'b0;

        if (fall) begin
            to_d = '0;
            if (bitcnt_q == bitcnt_t'(PS2_BIT_STOP)) begin
                // Last bit: the whole frame is judged on this cycle.
                bitcnt_d = '0;
                if (start_q == PS2_START && odd_parity_ok(shift_q, parity_q) &&
                    rx_bit == PS2_STOP) begin
                    frame_good = 1'b1;
                    if (fifo_full && !pop_eff) overflow_d = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                bitcnt_d = bitcnt_q + 4'd1;
                if (bitcnt_q == '0)
                    start_d = rx_bit;
                else if (bitcnt_q == bitcnt_t'(PS2_BIT_PARITY))
                    parity_d = rx_bit;
                else if (bitcnt_q >= bitcnt_t'(PS2_BIT_DATA_LSB))
                    shift_d = {rx_bit, shift_q[7:1]};   // LSB arrives first
            end
        end else if (bitcnt_q != '0) begin
            // Stalled mid-frame: abandon the partial byte silently.
            if (to_q == TO_W'(TIMEOUT - 1)) begin
                bitcnt_d = '0;
                to_d     = '0;
            end else begin
                to_d = to_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            start_q     <= 1'b0;
            parity_q    <= 1'b0;
            to_q        <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            start_q     <= start_d;
            parity_q    <= parity_d;
            to_q        <= to_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    ps2_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (8)
    ) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (frame_good),
        .pop   (~nextdata_n),
        .wdata (shift_q),
        .rdata (data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign ready     = ~fifo_empty;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule

// File: doc/ps2_receiver.md
Name: ps2_receiver

Overview:
PS/2 device-to-host receiver that sits directly upstream of the keyboard scan-code handler. It synchronises the raw PS/2 clock and data lines into `clk`, deframes 11-bit PS/2 frames and checks start, parity and stop. Good bytes go into a small FIFO, which the handler drains through the `ready`/`nextdata_n` handshake. Bad frames, overflow and line stalls are handled locally so the handler only ever sees valid scan-code bytes.

Parameters:
- `DEPTH_LOG2`, 3, log2 of FIFO depth (default 8 entries).
- `TIMEOUT`, 50000, idle `clk` cycles mid-frame before the partial frame is abandoned (1 ms at 50 MHz).

Ports:
- `clk`  in  1  system clock.
- `clr`  in  1  synchronous active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock line, asynchronous, idle high.
- `ps2_data`  in  1  raw PS/2 data line, asynchronous, idle high.
- `nextdata_n`  in  1  active-low pop request from the consumer.
- `data`  out  8  byte at the FIFO head; valid while `ready`=1.
- `ready`  out  1  FIFO non-empty.
- `overflow`  out  1  sticky: a good byte was dropped because the FIFO was full.
- `frame_err`  out  1  one-cycle pulse: a frame was discarded (bad start, parity or stop).

Behaviour:
- Interface: one clock `clk`; reset `clr` is synchronous and active-high, sampled only on the `clk` rising edge.
- Reset values: `ready`=0, `overflow`=0, `frame_err`=0. `data` is don't-care while `ready`=0. FIFO read/write pointers, bit counter and timeout counter are 0. All synchronizer and history flops are 1 (idle), so no false edge is seen after reset.
- Synchronisation:
  - `ps2_clk` and `ps2_data` each pass through 2 flops (s1, s2); `ps2_clk` has a third history flop (s3).
  - Falling edge is detected when s3=1 and s2=0. On that cycle the bit value is the data s2.
- Frame state: a bit counter `bitcnt` runs 0..10 (`IDLE` = `bitcnt` 0 with no frame in progress).
  - Bit 0 is the start bit and must be 0.
  - Bits 1–8 are data, LSB first, shifted into an 8-bit register.
  - Bit 9 is odd parity: XOR of the 8 data bits and the parity bit must be 1.
  - Bit 10 is the stop bit and must be 1.
- On the 11th edge, `bitcnt` returns to 0 and the frame is evaluated on that same cycle:
  - Good frame and FIFO not full: push.
  - Good frame and FIFO full: no push, `overflow` set to 1.
  - Any check fails: no push, `frame_err`=1 for exactly one cycle.
- Latency: a pin falling edge that meets setup before `clk` edge N is detected after edge N+1 and pushed at edge N+2. `ready` reads 1 after edge N+2, i.e. 3 `clk` edges total for the stop-bit edge.
- Timeout:
  - The counter runs only while `bitcnt`≠0 and clears on every detected falling edge.
  - On reaching `TIMEOUT`, `bitcnt` returns to 0 and the partial byte is dropped silently (no `frame_err`).
- FIFO:
  - Depth 2^`DEPTH_LOG2`; pointers are `DEPTH_LOG2`+1 bits wide.
  - Full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
  - `data` = mem[rptr], combinational from registered state.
  - Pop occurs on any `clk` edge where `nextdata_n`=0 and `ready`=1. Pop with `ready`=0 is ignored.
  - Each cycle with `nextdata_n` low pops one entry, so the consumer holds it low for exactly one cycle per byte.
  - Push and pop on the same cycle are both performed when the FIFO is non-empty. If the FIFO is full and a pop happens that cycle, the push succeeds (pop frees the slot first) and `overflow` is not set.
  - Pointers wrap modulo 2^(`DEPTH_LOG2`+1).
- `overflow` clears only on `clr`.
- `clr` mid-frame or with the FIFO non-empty discards everything; no `frame_err` pulse is emitted.

Decomposition:
- Shared package `ps2_pkg` holds:
  - `PS2_FRAME_BITS`=11, `PS2_START`=0, `PS2_STOP`=1.
  - Bit-index constants for data LSB (1), parity (9) and stop (10).
- Sub-module `ps2_fifo`: parameterised synchronous FIFO with inputs `push`, `pop`, `wdata` and outputs `rdata`, `empty`, `full`, and synchronous active-high `clr`. The top level keeps the synchronizer, deframer and timeout.

Test Plan:
1. Scan-code frame 0x1C, parity 0, ~12 kHz bit clock → after stop edge + 3 `clk` edges: `ready`=1, `data`=0x1C, `frame_err` never 1. Pulse `nextdata_n` low 1 cycle → `ready`=0.
2. Frames F0, 1C back-to-back with no pops → `ready` stays 1. Successive pops yield 0xF0 then 0x1C, then `ready`=0.
3. Frame 0x1C with parity bit 1 (wrong) → one-cycle `frame_err`, `ready` stays 0. Repeat with stop bit 0 → same.
4. 9 good frames 0x01..0x09 with no pops (`DEPTH_LOG2`=3) → `overflow`=1 after the 9th. Popping yields 0x01..0x08. `overflow` stays 1 until `clr`.
5. Send start + 4 data bits, then hold `ps2_clk` high for `TIMEOUT`+5 cycles, then a full 0x5A frame → only 0x5A appears, no `frame_err`.
6. FIFO full (8 entries); the 9th frame's push cycle coincides with `nextdata_n`=0 → no `overflow`, entry count stays 8, 9th byte is read last. Separately, assert `clr` at bit 5 of a frame → `ready`=0, `overflow`=0; the next complete frame is received correctly.
